// File: rtl/ysyx_23060061_decode_stage_if.sv
// Fetch-to-execute bus of the decode stage.
// Carries the fetch handshake and beat, the flush request, and the
// decoded execute-side beat with its handshake.
interface ysyx_23060061_decode_stage_if #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_inst;
   logic [XLEN-1:0]    in_pc;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_pc;
   logic [XLEN-1:0]    out_imm;
   logic [4:0]         out_rs1;
   logic [4:0]         out_rs2;
   logic [4:0]         out_rd;
   logic [2:0]         out_instType;
   logic               out_RegWrite;
   logic [1:0]         out_MemRW;
   logic [2:0]         out_memFunct3;
   logic               out_ebreak;
   logic               out_jump;
   logic               out_branch;
   logic [2:0]         out_brFunct3;
   logic               out_aluAsel;
   logic               out_aluBsel;
   logic [1:0]         out_WBSel;
   logic [ALUOP_W-1:0] out_aluOp;
   logic               out_illegal;

   // Decode stage side
   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_instType, out_RegWrite, out_MemRW, out_memFunct3, out_ebreak,
             out_jump, out_branch, out_brFunct3, out_aluAsel, out_aluBsel,
             out_WBSel, out_aluOp, out_illegal
   );

   // Fetch / execute side
   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_instType, out_RegWrite, out_MemRW, out_memFunct3, out_ebreak,
             out_jump, out_branch, out_brFunct3, out_aluAsel, out_aluBsel,
             out_WBSel, out_aluOp, out_illegal
   );
endinterface

// File: rtl/ysyx_23060061_decode_stage.sv
// RV32I decode stage with a two-entry skid buffer (main + spare).
// Optional feature: define YSYX_23060061_RV32M_EN to decode the M extension
// (OP opcode with funct7=0000001); without it those encodings are illegal.
// aluAsel=1 selects PC as ALU operand A, aluBsel=1 selects the immediate as
// operand B. WBSel: 00 memory data, 01 ALU result, 10 PC+4.
module ysyx_23060061_decode_stage #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 5
) (
   input logic                      clk,
   input logic                      rst,
   ysyx_23060061_decode_stage_if.slave bus
);

   localparam logic [2:0] TYPE_R = 3'd0;
   localparam logic [2:0] TYPE_I = 3'd1;
   localparam logic [2:0] TYPE_S = 3'd2;
   localparam logic [2:0] TYPE_B = 3'd3;
   localparam logic [2:0] TYPE_U = 3'd4;
   localparam logic [2:0] TYPE_J = 3'd5;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_ADDC = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
   localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);
`ifdef YSYX_23060061_RV32M_EN
   localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(16);
`endif

   typedef struct packed {
      logic [XLEN-1:0]    imm;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic [2:0]         instType;
      logic               RegWrite;
      logic [1:0]         MemRW;
      logic [2:0]         memFunct3;
      logic               ebreak;
      logic               jump;
      logic               branch;
      logic [2:0]         brFunct3;
      logic               aluAsel;
      logic               aluBsel;
      logic [1:0]         WBSel;
      logic [ALUOP_W-1:0] aluOp;
      logic               illegal;
   } dec_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      dec_t            dec;
   } beat_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t              d;
      logic [6:0]        opc;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic signed [31:0] imm32;
      logic              ok;
      logic              shamt_ok;
      opc      = inst[6:0];
      f3       = inst[14:12];
      f7       = inst[31:25];
      imm32    = '0;
      ok       = 1'b1;
      // A 5-bit shamt must leave inst[25] clear; a 6-bit shamt uses it
      shamt_ok = (XLEN == 64) || !inst[25];
      d        = '0;
      d.rs1    = inst[19:15];
      d.rs2    = inst[24:20];
      d.rd     = inst[11:7];
      case (opc)
         7'b0110111: begin // LUI
            d.instType = TYPE_U;  imm32 = {inst[31:12], 12'b0};
            d.RegWrite = 1'b1;    d.aluBsel = 1'b1;
            d.WBSel    = 2'b01;   d.aluOp   = ALU_PASSB;
         end
         7'b0010111: begin // AUIPC
            d.instType = TYPE_U;  imm32 = {inst[31:12], 12'b0};
            d.RegWrite = 1'b1;    d.aluAsel = 1'b1; d.aluBsel = 1'b1;
            d.WBSel    = 2'b01;   d.aluOp   = ALU_ADD;
         end
         7'b1101111: begin // JAL
            d.instType = TYPE_J;
            imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            d.RegWrite = 1'b1;    d.jump    = 1'b1;
            d.aluAsel  = 1'b1;    d.aluBsel = 1'b1;
            d.WBSel    = 2'b10;   d.aluOp   = ALU_ADD;
         end
         7'b1100111: begin // JALR
            ok         = (f3 == 3'b000);
            d.instType = TYPE_I;  imm32 = {{20{inst[31]}}, inst[31:20]};
            d.RegWrite = 1'b1;    d.jump    = 1'b1; d.aluBsel = 1'b1;
            d.WBSel    = 2'b10;   d.aluOp   = ALU_ADDC;
         end
         7'b1100011: begin // branches, compared downstream
            ok         = (f3 != 3'b010) && (f3 != 3'b011);
            d.instType = TYPE_B;
            imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            d.branch   = 1'b1;    d.brFunct3 = f3;
            d.aluOp    = ALU_SUB;
         end
         7'b0000011: begin // loads
            ok         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            d.instType = TYPE_I;  imm32 = {{20{inst[31]}}, inst[31:20]};
            d.RegWrite = 1'b1;    d.MemRW   = 2'b10; d.memFunct3 = f3;
            d.aluBsel  = 1'b1;    d.WBSel   = 2'b00; d.aluOp     = ALU_ADD;
         end
         7'b0100011: begin // stores
            ok         = !f3[2] && (f3 != 3'b011);
            d.instType = TYPE_S;  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            d.MemRW    = 2'b01;   d.memFunct3 = f3;
            d.aluBsel  = 1'b1;    d.aluOp     = ALU_ADD;
         end
         7'b0010011: begin // OP-IMM
            d.instType = TYPE_I;  imm32 = {{20{inst[31]}}, inst[31:20]};
            d.RegWrite = 1'b1;    d.aluBsel = 1'b1; d.WBSel = 2'b01;
            case (f3)
               3'b000:  d.aluOp = ALU_ADD;
               3'b010:  d.aluOp = ALU_SLT;
               3'b011:  d.aluOp = ALU_SLTU;
               3'b100:  d.aluOp = ALU_XOR;
               3'b110:  d.aluOp = ALU_OR;
               3'b111:  d.aluOp = ALU_AND;
               3'b001: begin
                  d.aluOp = ALU_SLL;
                  ok      = shamt_ok && (inst[31:26] == 6'b0);
               end
               default: begin
                  d.aluOp = inst[30] ? ALU_SRA : ALU_SRL;
                  ok      = shamt_ok && ({inst[31], inst[29:26]} == 5'b0);
               end
            endcase
         end
         7'b0110011: begin // OP
            d.instType = TYPE_R;
            d.RegWrite = 1'b1;    d.WBSel = 2'b01;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  d.aluOp = ALU_ADD;
                  3'b001:  d.aluOp = ALU_SLL;
                  3'b010:  d.aluOp = ALU_SLT;
                  3'b011:  d.aluOp = ALU_SLTU;
                  3'b100:  d.aluOp = ALU_XOR;
                  3'b101:  d.aluOp = ALU_SRL;
                  3'b110:  d.aluOp = ALU_OR;
                  default: d.aluOp = ALU_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               if (f3 == 3'b000)      d.aluOp = ALU_SUB;
               else if (f3 == 3'b101) d.aluOp = ALU_SRA;
               else                   ok = 1'b0;
`ifdef YSYX_23060061_RV32M_EN
            end else if (f7 == 7'b0000001) begin
               d.aluOp = ALU_MUL + ALUOP_W'(f3);
`endif
            end else begin
               ok = 1'b0;
            end
         end
         7'b0001111: begin // FENCE decodes as a no-op
            ok         = (f3 == 3'b000);
            d.instType = TYPE_I;
         end
         7'b1110011: begin // ECALL / EBREAK
            d.instType = TYPE_I;
            if (inst == 32'h0010_0073)      d.ebreak = 1'b1;
            else if (inst != 32'h0000_0073) ok = 1'b0;
         end
         default: ok = 1'b0;
      endcase
      d.imm = XLEN'(imm32);
      if (!ok) begin
         d         = '0;
         d.illegal = 1'b1;
      end
      if (d.rd == 5'd0) d.RegWrite = 1'b0;
      return d;
   endfunction

   state_t state_q, state_d;
   logic   in_ready_q, in_ready_d;
   beat_t  main_q, main_d, spare_q, new_beat;
   logic   accept, drain, load_main, load_spare, main_from_spare;

   assign accept = bus.in_valid & in_ready_q & ~bus.flush;
   assign drain  = (state_q != EMPTY) & bus.out_ready & ~bus.flush;

   // Decode the beat currently offered by fetch
   always_comb begin
      new_beat     = '0;
      new_beat.pc  = bus.in_pc;
      new_beat.dec = decode(bus.in_inst);
   end

   // Buffer occupancy next state and entry load controls
   always_comb begin
      state_d         = state_q;
      load_main       = 1'b0;
      load_spare      = 1'b0;
      main_from_spare = 1'b0;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (accept && drain) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_d    = TWO;
                  load_spare = 1'b1;
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (drain) begin
               state_d         = ONE;
               load_main       = 1'b1;
               main_from_spare = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != TWO);
      main_d     = main_from_spare ? spare_q : new_beat;
   end

   // Occupancy state and registered ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Main and spare beat storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q  <= '0;
         spare_q <= '0;
      end else begin
         if (load_main)  main_q  <= main_d;
         if (load_spare) spare_q <= new_beat;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = (state_q != EMPTY);
   assign bus.out_pc        = main_q.pc;
   assign bus.out_imm       = main_q.dec.imm;
   assign bus.out_rs1       = main_q.dec.rs1;
   assign bus.out_rs2       = main_q.dec.rs2;
   assign bus.out_rd        = main_q.dec.rd;
   assign bus.out_instType  = main_q.dec.instType;
   assign bus.out_RegWrite  = main_q.dec.RegWrite;
   assign bus.out_MemRW     = main_q.dec.MemRW;
   assign bus.out_memFunct3 = main_q.dec.memFunct3;
   assign bus.out_ebreak    = main_q.dec.ebreak;
   assign bus.out_jump      = main_q.dec.jump;
   assign bus.out_branch    = main_q.dec.branch;
   assign bus.out_brFunct3  = main_q.dec.brFunct3;
   assign bus.out_aluAsel   = main_q.dec.aluAsel;
   assign bus.out_aluBsel   = main_q.dec.aluBsel;
   assign bus.out_WBSel     = main_q.dec.WBSel;
   assign bus.out_aluOp     = main_q.dec.aluOp;
   assign bus.out_illegal   = main_q.dec.illegal;

endmodule

// File: tb/tb_ysyx_23060061_decode_stage.sv
// Directed bench for ysyx_23060061_decode_stage: decode vectors, skid
// buffer ordering/backpressure, flush and asynchronous reset.
module tb_ysyx_23060061_decode_stage;

   localparam int XLEN    = 32;
   localparam int ALUOP_W = 5;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   ysyx_23060061_decode_stage_if #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) bus ();

   ysyx_23060061_decode_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat with out_ready high; it is checked one edge later
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      bus.in_valid  = 1'b1;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0;
      bus.in_pc     = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
      chk("rst_out_imm",   64'(bus.out_imm),   64'd0);
      chk("rst_regwrite",  64'(bus.out_RegWrite), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // addi x1,x0,5
      issue(32'h0050_0093, 32'h100);
      chk("addi_valid",  64'(bus.out_valid),    64'd1);
      chk("addi_pc",     64'(bus.out_pc),       64'h100);
      chk("addi_rd",     64'(bus.out_rd),       64'd1);
      chk("addi_imm",    64'(bus.out_imm),      64'd5);
      chk("addi_aluop",  64'(bus.out_aluOp),    64'd0);
      chk("addi_bsel",   64'(bus.out_aluBsel),  64'd1);
      chk("addi_wbsel",  64'(bus.out_WBSel),    64'd1);
      chk("addi_regw",   64'(bus.out_RegWrite), 64'd1);
      chk("addi_ill",    64'(bus.out_illegal),  64'd0);

      // lui x5,0x12345
      issue(32'h1234_52B7, 32'h104);
      chk("lui_imm",     64'(bus.out_imm),      64'h1234_5000);
      chk("lui_aluop",   64'(bus.out_aluOp),    64'd1);
      chk("lui_rd",      64'(bus.out_rd),       64'd5);
      chk("lui_type",    64'(bus.out_instType), 64'd4);

      // all-ones word is illegal
      issue(32'hFFFF_FFFF, 32'h108);
      chk("ill_flag",    64'(bus.out_illegal),  64'd1);
      chk("ill_regw",    64'(bus.out_RegWrite), 64'd0);
      chk("ill_memrw",   64'(bus.out_MemRW),    64'd0);
      chk("ill_jump",    64'(bus.out_jump),     64'd0);

      // mul x1,x1,x2
      issue(32'h0220_80B3, 32'h10C);
`ifdef YSYX_23060061_RV32M_EN
      chk("mul_aluop",   64'(bus.out_aluOp),    64'd16);
      chk("mul_ill",     64'(bus.out_illegal),  64'd0);
      chk("mul_wbsel",   64'(bus.out_WBSel),    64'd1);
`else
      chk("mul_ill",     64'(bus.out_illegal),  64'd1);
      chk("mul_regw",    64'(bus.out_RegWrite), 64'd0);
`endif

      // sw x2,8(x1)
      issue(32'h0020_A423, 32'h110);
      chk("sw_memrw",    64'(bus.out_MemRW),    64'd1);
      chk("sw_regw",     64'(bus.out_RegWrite), 64'd0);
      chk("sw_imm",      64'(bus.out_imm),      64'd8);
      chk("sw_type",     64'(bus.out_instType), 64'd2);
      chk("sw_f3",       64'(bus.out_memFunct3), 64'd2);

      // bne x1,x2,-4
      issue(32'hFE20_9EE3, 32'h114);
      chk("bne_branch",  64'(bus.out_branch),   64'd1);
      chk("bne_f3",      64'(bus.out_brFunct3), 64'd1);
      chk("bne_imm",     64'(bus.out_imm),      64'hFFFF_FFFC);
      chk("bne_regw",    64'(bus.out_RegWrite), 64'd0);
      chk("bne_type",    64'(bus.out_instType), 64'd3);

      // jal x1,8
      issue(32'h0080_00EF, 32'h118);
      chk("jal_jump",    64'(bus.out_jump),     64'd1);
      chk("jal_wbsel",   64'(bus.out_WBSel),    64'd2);
      chk("jal_imm",     64'(bus.out_imm),      64'd8);
      chk("jal_asel",    64'(bus.out_aluAsel),  64'd1);

      // jalr x0,0(x1): rd=0 suppresses the write
      issue(32'h0000_8067, 32'h11C);
      chk("jalr_jump",   64'(bus.out_jump),     64'd1);
      chk("jalr_aluop",  64'(bus.out_aluOp),    64'd2);
      chk("jalr_regw",   64'(bus.out_RegWrite), 64'd0);

      // srai x1,x1,3 and slli x1,x1,32 (inst[25] set)
      issue(32'h4030_D093, 32'h120);
      chk("srai_aluop",  64'(bus.out_aluOp),    64'd11);
      chk("srai_ill",    64'(bus.out_illegal),  64'd0);
      issue(32'h0200_9093, 32'h124);
      chk("slli32_ill",  64'(bus.out_illegal),  64'd1);

      // ebreak, lw x3,4(x2), addi x0,x0,5
      issue(32'h0010_0073, 32'h128);
      chk("ebreak_flag", 64'(bus.out_ebreak),   64'd1);
      chk("ebreak_ill",  64'(bus.out_illegal),  64'd0);
      issue(32'h0041_2183, 32'h12C);
      chk("lw_memrw",    64'(bus.out_MemRW),    64'd2);
      chk("lw_wbsel",    64'(bus.out_WBSel),    64'd0);
      chk("lw_regw",     64'(bus.out_RegWrite), 64'd1);
      chk("lw_imm",      64'(bus.out_imm),      64'd4);
      issue(32'h0050_0013, 32'h130);
      chk("x0_regw",     64'(bus.out_RegWrite), 64'd0);
      chk("x0_ill",      64'(bus.out_illegal),  64'd0);

      // drain to empty
      tick();
      chk("drain_valid", 64'(bus.out_valid),    64'd0);

      // three back-to-back beats against a stalled consumer
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h0050_0093;
      bus.in_pc     = 32'h200;
      tick();
      chk("skid_rdy1",   64'(bus.in_ready),     64'd1);
      bus.in_pc     = 32'h204;
      tick();
      chk("skid_rdy2",   64'(bus.in_ready),     64'd0);
      chk("skid_pcA",    64'(bus.out_pc),       64'h200);
      bus.in_pc     = 32'h208;
      tick();
      chk("skid_hold",   64'(bus.out_pc),       64'h200);
      chk("skid_rdy3",   64'(bus.in_ready),     64'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("skid_pcB",    64'(bus.out_pc),       64'h204);
      chk("skid_vB",     64'(bus.out_valid),    64'd1);
      tick();
      chk("skid_pcC",    64'(bus.out_pc),       64'h208);
      chk("skid_vC",     64'(bus.out_valid),    64'd1);
      bus.in_valid  = 1'b0;
      tick();
      chk("skid_empty",  64'(bus.out_valid),    64'd0);

      // fill both entries, then flush with a beat offered
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'h300;
      tick();
      bus.in_pc     = 32'h304;
      tick();
      chk("fl_full",     64'(bus.in_ready),     64'd0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_pc     = 32'h308;
      tick();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      chk("fl_valid",    64'(bus.out_valid),    64'd0);
      chk("fl_ready",    64'(bus.in_ready),     64'd1);
      tick();
      chk("fl_valid2",   64'(bus.out_valid),    64'd0);

      // asynchronous reset while both entries are full
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'h400;
      tick();
      bus.in_pc     = 32'h404;
      tick();
      bus.in_valid  = 1'b0;
      chk("ar_full",     64'(bus.out_valid),    64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid",    64'(bus.out_valid),    64'd0);
      chk("ar_ready",    64'(bus.in_ready),     64'd1);
      chk("ar_pc",       64'(bus.out_pc),       64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_after",    64'(bus.out_valid),    64'd0);

      // normal operation resumes after reset
      issue(32'h1234_52B7, 32'h500);
      chk("post_pc",     64'(bus.out_pc),       64'h500);
      chk("post_rd",     64'(bus.out_rd),       64'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_23060061_decode_stage.md
YSYX_23060061_DECODE_STAGE -- requirements
Module: ysyx_23060061_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter ALUOP_W, default 5, width of the aluOp field.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1, in_ready  out  1, in_inst  in  32, in_pc  in  XLEN: fetch-side handshake and beat.
REQ-006 flush  in  1  discard all buffered beats.
REQ-007 out_valid  out  1, out_ready  in  1: execute-side handshake.
REQ-008 out_pc  out  XLEN, out_imm  out  XLEN (sign-extended), out_rs1/out_rs2/out_rd  out  5 each.
REQ-009 out_instType  out  3: R/I/S/B/U/J codes from global.vh.
REQ-010 Control outputs, 1 bit unless stated: out_RegWrite, out_MemRW (2: 00 idle, 10 read, 01 write), out_memFunct3 (3), out_ebreak, out_jump, out_branch, out_brFunct3 (3), out_aluAsel, out_aluBsel, out_WBSel (2), out_aluOp (ALUOP_W), out_illegal.

Function
REQ-011 Decode covers full RV32I: LUI, AUIPC, JAL, JALR, 6 branches, LB/LH/LW/LBU/LHU, SB/SH/SW, 9 OP-IMM, 10 OP, FENCE (as no-op), ECALL, EBREAK.
REQ-012 aluOp codes: 0 add, 1 passB, 2 add-clear-lsb, 3 sub, 4 sltu, 5 slt, 6 xor, 7 or, 8 and, 9 sll, 10 srl, 11 sra.
REQ-013 Branches: out_branch=1, out_brFunct3=funct3, unsigned flag implied by funct3[1]; branch is resolved downstream, not in this block.
REQ-014 JAL/JALR: out_jump=1, WBSel=10 (PC+4); JALR uses aluOp 2.
REQ-015 Any unlisted opcode/funct3/funct7 combination: out_illegal=1, out_RegWrite=0, out_MemRW=00, out_jump=0, out_branch=0.
REQ-016 Shift-immediate legality: XLEN=32 requires inst[25]=0; XLEN=64 ignores inst[25] (6-bit shamt).
REQ-017 out_RegWrite forced 0 when rd=0.
REQ-018 Latency: 1 cycle from accepted beat (in_valid & in_ready) to out_valid.
REQ-019 Two-entry skid buffer: main output register plus one spare; in_ready is registered and drops only when both entries are full.
REQ-020 While out_valid & !out_ready, all out_* fields hold stable.
REQ-021 Beats leave in acceptance order; no beat is dropped or duplicated except by flush.
REQ-022 Simultaneous accept and drain on a full main entry: new beat goes to main, spare stays empty.
REQ-023 flush clears both entries next edge; an input beat offered in the flush cycle is discarded; out_ready ignored that cycle.
REQ-024 Buffer states: EMPTY, ONE, TWO; EMPTY->ONE on accept, ONE->TWO on accept without drain, TWO->ONE on drain, ONE->EMPTY on drain without accept, any->EMPTY on flush.

Reset
REQ-025 rst asserted: state EMPTY, out_valid=0, in_ready=1, all out_* data and control fields 0.
REQ-026 rst asserted mid-transfer discards all buffered beats immediately, without waiting for clk.

Configuration
REQ-027 Macro YSYX_23060061_RV32M_EN defined: OP with funct7=0000001 decodes as M extension, aluOp 16 mul, 17 mulh, 18 mulhsu, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu, WBSel=01.
REQ-028 Macro undefined: those encodings are illegal per REQ-015; RTL for them is not compiled.

Verification
REQ-029 Issue 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, aluOp=0, aluBsel=1, WBSel=01, RegWrite=1.
REQ-030 Issue 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, aluOp=1, rd=5, instType=U.
REQ-031 Issue 3 beats back-to-back with out_ready=0 -> in_ready=0 after 2nd beat; 3rd beat held upstream; out_ready=1 drains beats in order with no loss.
REQ-032 Two beats buffered, flush=1 for one cycle -> out_valid=0 next cycle, in_ready=1, old beats never appear.
REQ-033 Issue 0xFFFFFFFF -> out_illegal=1, RegWrite=0, MemRW=00; issue 0x022080B3 (mul x1,x1,x2) -> aluOp=16 with YSYX_23060061_RV32M_EN, out_illegal=1 without it.
REQ-034 Assert rst while TWO and out_ready=0 -> out_valid=0 and in_ready=1 before the next clk edge.
